// File: rtl/mem_bus_arbiter.sv
// Arbiter that shares the single-port program/data memory between the loader,
// the instruction fetcher and the decoder data path, one 3-cycle access at a time.
module mem_bus_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int LOCK_MAX   = 4
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  ld_req,
    input  logic                  ld_we,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_wdata,
    input  logic                  ld_lock,
    output logic                  ld_gnt,
    output logic                  ld_ack,

    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_ack,

    input  logic                  dt_req,
    input  logic                  dt_we,
    input  logic [ADDR_WIDTH-1:0] dt_addr,
    input  logic [DATA_WIDTH-1:0] dt_wdata,
    output logic                  dt_gnt,
    output logic                  dt_ack,

    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic                  busy
);

    localparam int                   CNT_WIDTH  = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_WIDTH-1:0] LOCK_LIMIT = CNT_WIDTH'(LOCK_MAX);
    localparam logic [1:0]           ID_LD      = 2'd0;
    localparam logic [1:0]           ID_IF      = 2'd1;
    localparam logic [1:0]           ID_DT      = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             rr_ptr_q, rr_ptr_d;
    logic [CNT_WIDTH-1:0]   lock_cnt_q, lock_cnt_d;
    logic [1:0]             winner_q, winner_d;
    logic                   is_read_q, is_read_d;
    logic [2:0]             gnt_q, gnt_d;
    logic [2:0]             ack_q, ack_d;
    logic                   mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]  mem_din_q, mem_din_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic                   busy_q, busy_d;

    logic [2:0]             req_vec;
    logic [2:0]             elig;
    logic                   lock_active;
    logic                   force_yield;
    logic                   ld_wins;
    logic [1:0]             rr_pick;
    logic [1:0]             win_id;
    logic [1:0]             rr_next;
    logic                   sel_we;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [DATA_WIDTH-1:0]  sel_wdata;

    assign req_vec = {dt_req, if_req, ld_req};

    // A locked loader keeps the bus until it has used up its burst allowance
    // while someone else is waiting; the yield round robin then skips it.
    always_comb begin
        lock_active = ld_lock & ld_req;
        force_yield = lock_active && (lock_cnt_q == LOCK_LIMIT) && (if_req || dt_req);
        ld_wins     = lock_active && !force_yield;
        elig        = force_yield ? {dt_req, if_req, 1'b0} : req_vec;
    end

    always_comb begin
        rr_pick = rr_ptr_q;
        case (rr_ptr_q)
            2'd0: begin
                if (elig[0])      rr_pick = 2'd0;
                else if (elig[1]) rr_pick = 2'd1;
                else if (elig[2]) rr_pick = 2'd2;
            end
            2'd1: begin
                if (elig[1])      rr_pick = 2'd1;
                else if (elig[2]) rr_pick = 2'd2;
                else if (elig[0]) rr_pick = 2'd0;
            end
            default: begin
                if (elig[2])      rr_pick = 2'd2;
                else if (elig[0]) rr_pick = 2'd0;
                else if (elig[1]) rr_pick = 2'd1;
            end
        endcase
    end

    always_comb begin
        win_id  = ld_wins ? ID_LD : rr_pick;
        rr_next = (rr_pick == 2'd2) ? 2'd0 : rr_pick + 2'd1;
    end

    // The fetcher never writes, so its access is always presented as a read.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = ld_addr;
        sel_wdata = ld_wdata;
        case (win_id)
            ID_IF: begin
                sel_we    = 1'b0;
                sel_addr  = if_addr;
                sel_wdata = '0;
            end
            ID_DT: begin
                sel_we    = dt_we;
                sel_addr  = dt_addr;
                sel_wdata = dt_wdata;
            end
            default: begin
                sel_we    = ld_we;
                sel_addr  = ld_addr;
                sel_wdata = ld_wdata;
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_cnt_d = lock_cnt_q;
        winner_d   = winner_q;
        is_read_d  = is_read_q;
        gnt_d      = 3'b000;
        ack_d      = 3'b000;
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        rdata_d    = rdata_q;
        busy_d     = busy_q;

        case (state_q)
            IDLE: begin
                mem_we_d = 1'b0;
                busy_d   = 1'b0;
                if (|req_vec) begin
                    state_d    = ACCESS;
                    winner_d   = win_id;
                    is_read_d  = !sel_we;
                    gnt_d      = 3'b001 << win_id;
                    busy_d     = 1'b1;
                    mem_we_d   = sel_we;
                    mem_addr_d = sel_addr;
                    if (sel_we) begin
                        mem_din_d = sel_wdata;
                    end
                    if (ld_wins) begin
                        if (lock_cnt_q != LOCK_LIMIT) begin
                            lock_cnt_d = lock_cnt_q + 1'b1;
                        end
                    end else begin
                        lock_cnt_d = '0;
                        rr_ptr_d   = rr_next;
                    end
                end
            end
            ACCESS: begin
                mem_we_d = 1'b0;
                state_d  = DONE;
            end
            DONE: begin
                if (is_read_q) begin
                    rdata_d = mem_dout;
                end
                ack_d   = 3'b001 << winner_q;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= ID_IF;
            lock_cnt_q <= '0;
            winner_q   <= ID_LD;
            is_read_q  <= 1'b0;
            gnt_q      <= 3'b000;
            ack_q      <= 3'b000;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            rdata_q    <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_cnt_q <= lock_cnt_d;
            winner_q   <= winner_d;
            is_read_q  <= is_read_d;
            gnt_q      <= gnt_d;
            ack_q      <= ack_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            rdata_q    <= rdata_d;
            busy_q     <= busy_d;
        end
    end

    assign ld_gnt   = gnt_q[ID_LD];
    assign if_gnt   = gnt_q[ID_IF];
    assign dt_gnt   = gnt_q[ID_DT];
    assign ld_ack   = ack_q[ID_LD];
    assign if_ack   = ack_q[ID_IF];
    assign dt_ack   = ack_q[ID_DT];
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign rdata    = rdata_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus random traffic, all judged
// against a transaction-level model of grants, acks and memory contents.
module tb_mem_bus_arbiter;

    localparam int AW       = 16;
    localparam int DW       = 8;
    localparam int LOCK_MAX = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          ld_req, ld_we, ld_lock;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          dt_req, dt_we;
    logic [AW-1:0] dt_addr;
    logic [DW-1:0] dt_wdata;
    logic          ld_gnt, ld_ack, if_gnt, if_ack, dt_gnt, dt_ack;
    logic [DW-1:0] rdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] memDout;
    logic          busy;

    mem_bus_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .LOCK_MAX  (LOCK_MAX)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .ld_req  (ld_req),
        .ld_we   (ld_we),
        .ld_addr (ld_addr),
        .ld_wdata(ld_wdata),
        .ld_lock (ld_lock),
        .ld_gnt  (ld_gnt),
        .ld_ack  (ld_ack),
        .if_req  (if_req),
        .if_addr (if_addr),
        .if_gnt  (if_gnt),
        .if_ack  (if_ack),
        .dt_req  (dt_req),
        .dt_we   (dt_we),
        .dt_addr (dt_addr),
        .dt_wdata(dt_wdata),
        .dt_gnt  (dt_gnt),
        .dt_ack  (dt_ack),
        .rdata   (rdata),
        .mem_we  (mem_we),
        .mem_addr(mem_addr),
        .mem_din (mem_din),
        .mem_dout(memDout),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Single-port synchronous memory: data appears the cycle after the address edge.
    bit [7:0] tbMem [0:65535];
    always @(posedge clk) begin
        if (mem_we) tbMem[mem_addr] <= mem_din;
        memDout <= tbMem[mem_addr];
    end

    int       errorCount = 0;
    int       checkCount = 0;
    int       edgeIdx = 0;
    int       gEdge = -100;
    int       nextFree = 0;
    int       rrPtr = 1;
    int       lockCnt = 0;
    int       txW = 0;
    bit       txWe = 1'b0;
    bit [7:0] refMem [0:65535];
    logic [AW-1:0] expAddr = '0;
    logic [DW-1:0] expDin = '0;
    logic [DW-1:0] expRdata = '0;
    logic [DW-1:0] readVal = '0;
    logic [2:0]    expGnt, expAck;
    logic          expBusy, expWe;
    bit   [2:0]    grantedNow = 3'b000;
    int            obsGnt[$];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", tag, edgeIdx, actual, expected);
        end
    endtask

    // Transaction view: a grant at edge g means ACCESS after g, DONE after g+1,
    // the ack cycle after g+2, and the next arbitration at edge g+3.
    task automatic modelEdge();
        bit [2:0] r;
        bit       skipLd;
        int       w;
        int       c;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit       we;
        grantedNow = 3'b000;
        if (reset) begin
            gEdge    = -100;
            nextFree = edgeIdx + 1;
            rrPtr    = 1;
            lockCnt  = 0;
            expAddr  = '0;
            expDin   = '0;
            expRdata = '0;
        end else begin
            if (edgeIdx == gEdge + 2 && !txWe) expRdata = readVal;
            r = {dt_req, if_req, ld_req};
            if (edgeIdx >= nextFree && r != 3'b000) begin
                w = -1;
                if (ld_lock && ld_req && !(lockCnt == LOCK_MAX && (if_req || dt_req))) begin
                    w = 0;
                    if (lockCnt < LOCK_MAX) lockCnt++;
                end else begin
                    skipLd = ld_lock && ld_req;
                    for (int k = 0; k < 3; k++) begin
                        c = (rrPtr + k) % 3;
                        if (w < 0 && r[c] && !(skipLd && c == 0)) w = c;
                    end
                    rrPtr   = (w + 1) % 3;
                    lockCnt = 0;
                end
                if (w == 0) begin
                    we = ld_we; a = ld_addr; d = ld_wdata;
                end else if (w == 1) begin
                    we = 1'b0; a = if_addr; d = '0;
                end else begin
                    we = dt_we; a = dt_addr; d = dt_wdata;
                end
                txW      = w;
                txWe     = we;
                gEdge    = edgeIdx;
                nextFree = edgeIdx + 3;
                expAddr  = a;
                if (we) begin
                    expDin     = d;
                    refMem[a]  = d;
                end else begin
                    readVal = refMem[a];
                end
                grantedNow[w] = 1'b1;
            end
        end
        expGnt  = (edgeIdx == gEdge)     ? (3'b001 << txW) : 3'b000;
        expAck  = (edgeIdx == gEdge + 2) ? (3'b001 << txW) : 3'b000;
        expBusy = (edgeIdx == gEdge) || (edgeIdx == gEdge + 1);
        expWe   = txWe && (edgeIdx == gEdge);
    endtask

    task automatic stepCycle();
        logic [2:0] g;
        logic [2:0] a;
        @(posedge clk);
        edgeIdx++;
        modelEdge();
        #1;
        g = {dt_gnt, if_gnt, ld_gnt};
        a = {dt_ack, if_ack, ld_ack};
        checkOutput("gnt", 32'(g), 32'(expGnt));
        checkOutput("ack", 32'(a), 32'(expAck));
        checkOutput("busy", 32'(busy), 32'(expBusy));
        checkOutput("mem_we", 32'(mem_we), 32'(expWe));
        checkOutput("mem_addr", 32'(mem_addr), 32'(expAddr));
        checkOutput("mem_din", 32'(mem_din), 32'(expDin));
        checkOutput("rdata", 32'(rdata), 32'(expRdata));
        if (g == 3'b001) obsGnt.push_back(0);
        if (g == 3'b010) obsGnt.push_back(1);
        if (g == 3'b100) obsGnt.push_back(2);
    endtask

    task automatic clearInputs();
        ld_req = 0; ld_we = 0; ld_lock = 0; ld_addr = '0; ld_wdata = '0;
        if_req = 0; if_addr = '0;
        dt_req = 0; dt_we = 0; dt_addr = '0; dt_wdata = '0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        stepCycle();
        reset = 1'b0;
    endtask

    // Each requester keeps its request stable until granted, then picks anew.
    task automatic applyStimulus();
        if (!ld_req || grantedNow[0]) begin
            ld_req   = 1'($urandom_range(0, 1));
            ld_we    = 1'($urandom_range(0, 1));
            ld_addr  = AW'($urandom_range(0, 15));
            ld_wdata = DW'($urandom);
        end
        if (!if_req || grantedNow[1]) begin
            if_req  = 1'($urandom_range(0, 1));
            if_addr = AW'($urandom_range(0, 15));
        end
        if (!dt_req || grantedNow[2]) begin
            dt_req   = 1'($urandom_range(0, 1));
            dt_we    = 1'($urandom_range(0, 1));
            dt_addr  = AW'($urandom_range(0, 15));
            dt_wdata = DW'($urandom);
        end
        if ($urandom_range(0, 7) == 0) ld_lock = ~ld_lock;
    endtask

    initial begin
        int rrExp[6];
        int lockExp[16];
        clearInputs();
        reset = 1'b1;
        stepCycle();
        stepCycle();
        checkOutput("resetBusy", 32'(busy), 32'd0);
        reset = 1'b0;

        // Preload mem[0x10] = 0xA9 through the loader port.
        ld_req = 1; ld_we = 1; ld_addr = 16'h0010; ld_wdata = 8'hA9;
        stepCycle();
        ld_req = 0;
        stepCycle();
        stepCycle();

        $display("[TB] single fetch");
        doReset();
        if_req = 1; if_addr = 16'h0010;
        stepCycle();
        checkOutput("fetchGnt", 32'(if_gnt), 32'd1);
        checkOutput("fetchWe", 32'(mem_we), 32'd0);
        if_req = 0;
        stepCycle();
        stepCycle();
        checkOutput("fetchAck", 32'(if_ack), 32'd1);
        checkOutput("fetchRdata", 32'(rdata), 32'hA9);

        $display("[TB] data write then read");
        dt_req = 1; dt_we = 1; dt_addr = 16'h0002; dt_wdata = 8'h04;
        stepCycle();
        checkOutput("staWeAccess", 32'(mem_we), 32'd1);
        dt_req = 0;
        stepCycle();
        checkOutput("staWeDone", 32'(mem_we), 32'd0);
        stepCycle();
        checkOutput("staAck", 32'(dt_ack), 32'd1);
        dt_req = 1; dt_we = 0;
        stepCycle();
        dt_req = 0;
        stepCycle();
        stepCycle();
        checkOutput("ldaAck", 32'(dt_ack), 32'd1);
        checkOutput("ldaRdata", 32'(rdata), 32'h04);

        $display("[TB] round robin");
        doReset();
        obsGnt.delete();
        ld_req = 1; if_req = 1; dt_req = 1; ld_lock = 0;
        rrExp = '{1, 2, 0, 1, 2, 0};
        for (int i = 0; i < 18; i++) stepCycle();
        checkOutput("rrCount", 32'(obsGnt.size()), 32'd6);
        for (int i = 0; i < 6 && i < obsGnt.size(); i++) checkOutput("rrOrder", 32'(obsGnt[i]), 32'(rrExp[i]));
        clearInputs();

        $display("[TB] lock limit");
        doReset();
        obsGnt.delete();
        ld_req = 1; ld_lock = 1; if_req = 1; if_addr = 16'h0001;
        lockExp = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 30; i++) stepCycle();
        if_req = 0;
        for (int i = 0; i < 18; i++) stepCycle();
        checkOutput("lockCount", 32'(obsGnt.size()), 32'd16);
        for (int i = 0; i < 16 && i < obsGnt.size(); i++) checkOutput("lockOrder", 32'(obsGnt[i]), 32'(lockExp[i]));
        clearInputs();

        $display("[TB] reset during access");
        doReset();
        dt_req = 1; dt_we = 1; dt_addr = 16'h0030; dt_wdata = 8'h55;
        stepCycle();
        checkOutput("abortGnt", 32'(dt_gnt), 32'd1);
        dt_req = 0;
        reset = 1'b1;
        stepCycle();
        reset = 1'b0;
        checkOutput("abortOutputs", 32'({dt_gnt, dt_ack, mem_we, busy, rdata, mem_din}), 32'd0);
        checkOutput("abortAddr", 32'(mem_addr), 32'd0);
        stepCycle();
        stepCycle();
        checkOutput("abortNoAck", 32'(dt_ack), 32'd0);
        ld_req = 1; if_req = 1; dt_req = 1; dt_we = 0;
        stepCycle();
        checkOutput("abortRrPtr", 32'(if_gnt), 32'd1);
        clearInputs();
        stepCycle();
        stepCycle();

        $display("[TB] random traffic");
        doReset();
        for (int i = 0; i < 1000; i++) begin
            applyStimulus();
            stepCycle();
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Arbitrates the single-port `mem` block between three requesters: the program/DMA loader (ld), the instruction fetcher (if, read-only) and the decoder's data path (dt, LDA/STA-style loads and stores).
- Sequences each access as a fixed 3-cycle transaction: grant, memory access, acknowledge.
- Replaces the hard-wired `addr`/`we` sharing between the fetcher, the decoder and the loader.
- Sits between those requesters and `mem`, on the CPU clock.

Parameters:
- ADDR_WIDTH, 16, address width (matches `ADDR_WIDTH).
- DATA_WIDTH, 8, data width (matches `REG_WIDTH).
- LOCK_MAX, 4, maximum consecutive locked loader grants while another requester is waiting.

Ports:
- clk  in  1  system clock; everything is rising-edge.
- reset  in  1  synchronous, active-high reset.
- ld_req  in  1  loader request.
- ld_we  in  1  loader access is a write (1) or read (0).
- ld_addr  in  ADDR_WIDTH  loader address.
- ld_wdata  in  DATA_WIDTH  loader write data.
- ld_lock  in  1  loader requests priority bus lock (burst load).
- ld_gnt  out  1  loader request accepted.
- ld_ack  out  1  loader transaction complete.
- if_req  in  1  fetch request (always a read).
- if_addr  in  ADDR_WIDTH  fetch address.
- if_gnt  out  1  fetch request accepted.
- if_ack  out  1  fetch transaction complete.
- dt_req  in  1  data request.
- dt_we  in  1  data access is a write.
- dt_addr  in  ADDR_WIDTH  data address.
- dt_wdata  in  DATA_WIDTH  data write data.
- dt_gnt  out  1  data request accepted.
- dt_ack  out  1  data transaction complete.
- rdata  out  DATA_WIDTH  read data; valid while any *_ack is high for a read.
- mem_we  out  1  to mem.we.
- mem_addr  out  ADDR_WIDTH  to mem.addr.
- mem_din  out  DATA_WIDTH  to mem.din.
- mem_dout  in  DATA_WIDTH  from mem.dout; valid the cycle after the edge that sampled mem_addr.
- busy  out  1  high in ACCESS and DONE.

Behaviour:
- All outputs are registered.
- Reset (synchronous) values:
  - state=IDLE, rr_ptr=1 (if), lock_cnt=0.
  - all gnt/ack=0, mem_we=0, mem_addr=0, mem_din=0, rdata=0, busy=0.
- FSM: IDLE -> ACCESS -> DONE -> IDLE. Requests are sampled only in IDLE.
- IDLE, any req high: choose a winner W.
  - Load mem_addr/mem_we/mem_din from W. mem_we is forced 0 for if; mem_din holds its previous value on reads.
  - Set W_gnt=1 and go to ACCESS.
- IDLE, no req: remain in IDLE; mem_we=0.
- ACCESS: gnt is high for exactly this cycle. Memory samples at the edge that ends ACCESS. At that edge, mem_we<=0, gnt<=0, go to DONE.
- DONE: at the edge that ends DONE:
  - rdata<=mem_dout on a read; rdata is held on a write.
  - W_ack<=1 for exactly one cycle, the next IDLE cycle.
  - go to IDLE.
- Latency and throughput:
  - Request sampled at edge E0 -> gnt in the cycle after E0, ack in cycle E0+3.
  - Back-to-back throughput is one access per 3 cycles.
  - The ack cycle is an IDLE cycle and may arbitrate the next request.
- Requester rule:
  - Hold req/addr/we/wdata stable until gnt is seen.
  - Drop req in the gnt cycle unless a further access is wanted.
  - A req still high in an IDLE cycle is a new request.
- Arbitration when ld_lock=0: 3-way round robin over {0:ld, 1:if, 2:dt}.
  - Search starts at rr_ptr; rr_ptr<=(W+1) mod 3 after the grant.
  - lock_cnt<=0.
- Arbitration when ld_lock=1 and ld_req=1:
  - The loader wins unless lock_cnt==LOCK_MAX and (if_req|dt_req).
  - On a loader win: lock_cnt<=lock_cnt+1, saturating at LOCK_MAX. rr_ptr is unchanged.
  - Forced yield: the round robin runs over {if, dt} only, starting at rr_ptr (ld skipped). rr_ptr is updated and lock_cnt<=0.
  - If no other requester is waiting, the loader is granted indefinitely. lock_cnt still counts, saturating.
- Any grant to if or dt clears lock_cnt.
- ld_lock=1 with ld_req=0: normal round robin.
- Reset mid-transaction:
  - In ACCESS, the edge that applies reset is also the mem sampling edge, so a pending write may land in mem.
  - No ack is issued for an aborted transaction. The FSM returns to IDLE with reset values.
- No grant is ever issued outside IDLE. At most one gnt and at most one ack are high in any cycle.

Test Plan:
- Single fetch: after reset, if_req=1, if_addr=0x0010, mem[0x10]=0xA9 -> if_gnt high in cycle 1, mem_we=0, if_ack high in cycle 3 with rdata=0xA9.
- Data write then read: dt STA 0x0002 with dt_wdata=0x04; then dt read of 0x0002 -> first dt_ack with mem_we pulsed exactly in ACCESS; second dt_ack with rdata=0x04.
- Round robin: ld_req, if_req and dt_req all held high with ld_lock=0 from reset -> grant order if, dt, ld, if, dt, …; a new gnt every 3 cycles.
- Lock limit: LOCK_MAX=4, ld_lock=1, ld_req and if_req held high -> grants ld ×4, if ×1, ld ×4, if ×1; with if_req=0 the loader is granted continuously.
- Reset in ACCESS during a dt write of 0x55 -> no dt_ack; all outputs at reset values next cycle; state IDLE; rr_ptr=1.
- Busy/ack invariants over 1000 random cycles:
  - gnt only follows an IDLE cycle.
  - acks appear exactly 2 cycles after the matching gnt.
  - never two gnt or two ack high together.
  - every read's rdata matches a reference memory model.
